v_pipe_query_rpl: RTL



---
 rtl/v_pkg.sv | 61 ++++++
 rtl/v_pipe_query_hazard.sv | 23 ++
 rtl/v_pipe_query_rpl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/v_pkg.sv
// Shared types for the list-query / update pipelines: state-table layout, query
// error flags, hazard policy, plus the level decode and key/volume select primitives.
package v_pkg;

    localparam int ENTRIES_N    = 4;
    localparam int UPD_STAGES_N = 5;
    localparam int ID_W         = 8;
    localparam int LEVEL_W      = 3;
    localparam int KEY_W        = 16;
    localparam int VOLUME_W     = 16;
    localparam int LISTSIZE_W   = $clog2(ENTRIES_N + 1);

    typedef logic [ID_W-1:0]       id_t;
    typedef logic [ID_W-1:0]       addr_t;
    typedef logic [LEVEL_W-1:0]    level_t;
    typedef logic [KEY_W-1:0]      key_t;
    typedef logic [VOLUME_W-1:0]   volume_t;
    typedef logic [LISTSIZE_W-1:0] listsize_t;

    typedef struct packed {
        logic [ENTRIES_N-1:0]    vld;
        listsize_t               listsize;
        key_t [ENTRIES_N-1:0]    key;
        volume_t [ENTRIES_N-1:0] volume;
    } state_t;

    typedef struct packed {
        logic invalid;
        logic busy;
    } query_err_t;

    typedef enum logic {
        BUSY_ERROR  = 1'b0,
        BUSY_REPLAY = 1'b1
    } busy_mode_t;

    function automatic logic [ENTRIES_N-1:0] dec(input level_t level);
        logic [ENTRIES_N-1:0] d;
        d = '0;
        for (int i = 0; i < ENTRIES_N; i++) d[i] = (level == level_t'(i));
        return d;
    endfunction

    // One-hot AND-OR selects; an all-zero select yields zero.
    function automatic key_t mux_key(input logic [ENTRIES_N-1:0] sel,
                                     input key_t [ENTRIES_N-1:0] din);
        key_t r;
        r = '0;
        for (int i = 0; i < ENTRIES_N; i++) if (sel[i]) r = r | din[i];
        return r;
    endfunction

    function automatic volume_t mux_volume(input logic [ENTRIES_N-1:0] sel,
                                           input volume_t [ENTRIES_N-1:0] din);
        volume_t r;
        r = '0;
        for (int i = 0; i < ENTRIES_N; i++) if (sel[i]) r = r | din[i];
        return r;
    endfunction

endpackage

// File: rtl/v_pipe_query_hazard.sv
// N-way product-ID compare against the snooped update-pipeline stages.
module v_pipe_query_hazard
    import v_pkg::*;
#(
    parameter int UPD_STAGES_N = v_pkg::UPD_STAGES_N
) (
    input  id_t                          i_prod_id,
    input  logic [UPD_STAGES_N-1:0]      i_upd_vld_r,
    input  id_t [UPD_STAGES_N-1:0]       i_upd_prod_id_r,
    output logic                         o_busy
);

    logic [UPD_STAGES_N-1:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k < UPD_STAGES_N; k++)
            hit[k] = i_upd_vld_r[k] & (i_upd_prod_id_r[k] == i_prod_id);
    end

    assign o_busy = |hit;

endmodule

// File: rtl/v_pipe_query_rpl.sv
// List-query pipeline: S0 issues the state-table read (or parks the query while an
// update to the same ID is in flight), S1 formats the response from the read data.
//
//   state | meaning
//   IDLE  | accepting queries; candidate is the bus query
//   HOLD  | replaying a parked query; candidate is the hold register
module v_pipe_query_rpl
    import v_pkg::*;
#(
    parameter int         ENTRIES_N    = v_pkg::ENTRIES_N,
    parameter int         UPD_STAGES_N = v_pkg::UPD_STAGES_N,
    parameter busy_mode_t BUSY_MODE    = BUSY_ERROR,
    parameter int         RETRY_MAX    = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_lut_vld,
    output logic                     o_lut_rdy,
    input  id_t                      i_lut_prod_id,
    input  level_t                   i_lut_level,
    output logic                     o_lut_vld_r,
    output key_t                     o_lut_key,
    output volume_t                  o_lut_size,
    output listsize_t                o_lut_listsize,
    output logic                     o_lut_error,
    output query_err_t               o_lut_err_code,
    output logic [15:0]              o_busy_cnt_r,
    output logic                     o_state_ren,
    output addr_t                    o_state_raddr,
    input  state_t                   i_state_rdata,
    input  logic [UPD_STAGES_N-1:0]  i_upd_vld_r,
    input  id_t [UPD_STAGES_N-1:0]   i_upd_prod_id_r
);

    localparam int RETRY_W = $clog2(RETRY_MAX + 1);

    typedef enum logic {IDLE, HOLD} fsm_t;

    fsm_t                 state_r, state_nxt;
    logic [RETRY_W-1:0]   retry_cnt_r, retry_cnt_nxt;
    id_t                  hold_id_r;
    level_t               hold_level_r;
    logic                 hold_load;

    id_t                  cand_id;
    level_t               cand_level;
    logic                 busy;
    logic                 issue;
    logic                 issue_busy;
    logic                 busy_inc;

    level_t               s1_level_r;
    logic                 s1_busy_r;
    logic [v_pkg::ENTRIES_N-1:0] lvl_mask;
    logic [v_pkg::ENTRIES_N-1:0] level_dec;
    logic                 s1_invalid;

    v_pipe_query_hazard #(
        .UPD_STAGES_N (UPD_STAGES_N)
    ) u_hazard (
        .i_prod_id       (cand_id),
        .i_upd_vld_r     (i_upd_vld_r),
        .i_upd_prod_id_r (i_upd_prod_id_r),
        .o_busy          (busy)
    );

    always_comb begin
        state_nxt     = state_r;
        retry_cnt_nxt = retry_cnt_r;
        hold_load     = 1'b0;
        issue         = 1'b0;
        issue_busy    = 1'b0;
        busy_inc      = 1'b0;
        o_lut_rdy     = 1'b0;
        cand_id       = i_lut_prod_id;
        cand_level    = i_lut_level;
        case (state_r)
            IDLE: begin
                o_lut_rdy = rst_n;
                if (i_lut_vld && rst_n) begin
                    if (BUSY_MODE == BUSY_ERROR) begin
                        issue      = 1'b1;
                        issue_busy = busy;
                        busy_inc   = busy;
                    end else if (!busy) begin
                        issue = 1'b1;
                    end else begin
                        hold_load     = 1'b1;
                        retry_cnt_nxt = RETRY_W'(1);
                        state_nxt     = HOLD;
                    end
                end
            end
            HOLD: begin
                cand_id    = hold_id_r;
                cand_level = hold_level_r;
                if (!busy) begin
                    issue         = 1'b1;
                    retry_cnt_nxt = '0;
                    state_nxt     = IDLE;
                end else if (retry_cnt_r == RETRY_W'(RETRY_MAX)) begin
                    issue         = 1'b1;
                    issue_busy    = 1'b1;
                    busy_inc      = 1'b1;
                    retry_cnt_nxt = '0;
                    state_nxt     = IDLE;
                end else begin
                    retry_cnt_nxt = retry_cnt_r + RETRY_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_state_ren   = issue & rst_n;
    assign o_state_raddr = addr_t'(cand_id);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            retry_cnt_r  <= '0;
            o_lut_vld_r  <= 1'b0;
            o_busy_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt;
            retry_cnt_r <= retry_cnt_nxt;
            o_lut_vld_r <= issue;
            if (busy_inc && o_busy_cnt_r != 16'hFFFF)
                o_busy_cnt_r <= o_busy_cnt_r + 16'd1;
        end
    end

    // Query payload and S1 context carry no reset; they are qualified by FSM/valid.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_id_r    <= i_lut_prod_id;
            hold_level_r <= i_lut_level;
        end
        if (issue) begin
            s1_level_r <= cand_level;
            s1_busy_r  <= issue_busy;
        end
    end

    always_comb begin
        lvl_mask = '0;
        for (int i = 0; i < v_pkg::ENTRIES_N; i++) lvl_mask[i] = (i < ENTRIES_N);
    end

    assign level_dec  = dec(s1_level_r) & lvl_mask;
    assign s1_invalid = ((level_dec & i_state_rdata.vld) == '0);

    assign o_lut_key              = mux_key(level_dec, i_state_rdata.key);
    assign o_lut_size             = mux_volume(level_dec, i_state_rdata.volume);
    assign o_lut_listsize         = i_state_rdata.listsize;
    assign o_lut_err_code.invalid = s1_invalid;
    assign o_lut_err_code.busy    = s1_busy_r;
    assign o_lut_error            = s1_invalid | s1_busy_r;

endmodule
